extend_unit_12to32: RTL and testbench

Registered 12-bit to 32-bit immediate extender for the RISC-V RV32 datapath. It takes the 12-bit immediate field from the decode stage and produces the 32-bit operand for the ALU or the address adder. It supports sign extension, zero extension and an optional branch-offset mode. The result is registered on the single core clock, with one cycle of latency.

---
 rtl/extend_unit_12to32.sv | 62 ++++++
 tb/tb_extend_unit_12to32.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/extend_unit_12to32.sv
// Registered 12-bit to 32-bit immediate extender for the RV32 datapath.
// Modes: 00 sign-extend, 01 zero-extend, 10 branch offset, 11 sign-extend.
// Optional feature macro: EXTEND_BRANCH_MODE_EN enables the branch-offset mode;
// without it, mode 10 falls back to plain sign-extend.
// One cycle of latency; synchronous active-low reset.
module extend_unit_12to32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] Extender,
   input  logic [1:0]  mode,
   input  logic        in_valid,
   output logic [31:0] Extendido,
   output logic        out_valid
);

   logic [31:0] ext_q, ext_d;
   logic        valid_q, valid_d;
   logic [31:0] sign_ext;
   logic [31:0] zero_ext;
`ifdef EXTEND_BRANCH_MODE_EN
   logic [31:0] branch_ext;
`endif

   // Candidate results for every supported mode.
   always_comb begin
      sign_ext   = {{20{Extender[11]}}, Extender};
      zero_ext   = {20'b0, Extender};
`ifdef EXTEND_BRANCH_MODE_EN
      branch_ext = {{19{Extender[11]}}, Extender, 1'b0};
`endif
   end

   // Next-state: capture the selected result on valid, otherwise hold the data.
   always_comb begin
      ext_d   = ext_q;
      valid_d = in_valid;
      if (in_valid) begin
         case (mode)
            2'b01:   ext_d = zero_ext;
`ifdef EXTEND_BRANCH_MODE_EN
            2'b10:   ext_d = branch_ext;
`endif
            default: ext_d = sign_ext;  // 00, 11, and 10 when branch mode is absent
         endcase
      end
   end

   // State registers; reset wins over a valid input in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ext_q   <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         ext_q   <= ext_d;
         valid_q <= valid_d;
      end
   end

   assign Extendido = ext_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_extend_unit_12to32.sv
// Self-checking bench for extend_unit_12to32: directed plan vectors plus
// randomized traffic against an arithmetic reference model.
module tb_extend_unit_12to32;

   logic        clk;
   logic        rst_n;
   logic [11:0] Extender;
   logic [1:0]  mode;
   logic        in_valid;
   logic [31:0] Extendido;
   logic        out_valid;

   int checks = 0;
   int errors = 0;

   // Bench-side copy of what the output register should hold.
   logic [31:0] exp_data;

   extend_unit_12to32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Extender  (Extender),
      .mode      (mode),
      .in_valid  (in_valid),
      .Extendido (Extendido),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: interpret the immediate as a signed/unsigned integer and scale.
   function automatic logic [31:0] model(input logic [11:0] imm, input logic [1:0] m);
      int s;
      int u;
      u = int'(imm);
      s = (u >= 2048) ? (u - 4096) : u;
      if (m == 2'd1) return 32'(u);
`ifdef EXTEND_BRANCH_MODE_EN
      if (m == 2'd2) return 32'(s * 2);
`endif
      return 32'(s);
   endfunction

   // Drive inputs away from the edge, then return just after the capturing edge.
   task automatic apply(input logic r, input logic v, input logic [1:0] m,
                        input logic [11:0] e);
      @(negedge clk);
      rst_n    = r;
      in_valid = v;
      mode     = m;
      Extender = e;
      @(posedge clk);
      #1;
      if (!r) exp_data = 32'h0;
      else if (v) exp_data = model(e, m);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b1, 2'd0, 12'hFFF);
         checks++;
         if (Extendido !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: data=%h valid=%b want data=00000000 valid=0",
                     Extendido, out_valid);
         end
      end
   endtask

   task automatic test_directed(input string name, input logic [1:0] m,
                                input logic [11:0] e, input logic [31:0] want);
      apply(1'b1, 1'b1, m, e);
      checks++;
      if (Extendido !== want || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s: in=%h mode=%0d data=%h valid=%b want data=%h valid=1",
                  name, e, m, Extendido, out_valid, want);
      end
   endtask

   task automatic test_sign_ext();
      test_directed("sign_pos0",   2'd0, 12'd0,   32'h0000_0000);
      test_directed("sign_pos100", 2'd0, 12'd100, 32'h0000_0064);
      test_directed("sign_pos250", 2'd0, 12'd250, 32'h0000_00FA);
      test_directed("sign_pos69",  2'd0, 12'd69,  32'h0000_0045);
      test_directed("sign_800",    2'd0, 12'h800, 32'hFFFF_F800);
      test_directed("sign_fff",    2'd0, 12'hFFF, 32'hFFFF_FFFF);
      test_directed("sign_7ff",    2'd0, 12'h7FF, 32'h0000_07FF);
      test_directed("mode11_800",  2'd3, 12'h800, 32'hFFFF_F800);
   endtask

   task automatic test_zero_ext();
      test_directed("zero_800", 2'd1, 12'h800, 32'h0000_0800);
      test_directed("zero_fff", 2'd1, 12'hFFF, 32'h0000_0FFF);
   endtask

   task automatic test_branch();
`ifdef EXTEND_BRANCH_MODE_EN
      test_directed("branch_fff", 2'd2, 12'hFFF, 32'hFFFF_FFFE);
      test_directed("branch_7ff", 2'd2, 12'h7FF, 32'h0000_0FFE);
`else
      test_directed("branch_off_fff", 2'd2, 12'hFFF, 32'hFFFF_FFFF);
      test_directed("branch_off_7ff", 2'd2, 12'h7FF, 32'h0000_07FF);
`endif
   endtask

   task automatic test_hold();
      test_directed("hold_load", 2'd0, 12'd100, 32'h0000_0064);
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 1'b0, 2'd0, 12'h800);
         checks++;
         if (Extendido !== 32'h0000_0064 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold: data=%h valid=%b want data=00000064 valid=0",
                     Extendido, out_valid);
         end
      end
      test_directed("hold_reload", 2'd0, 12'h800, 32'hFFFF_F800);
   endtask

   task automatic test_mid_reset();
      test_directed("midrst_pre", 2'd1, 12'h123, 32'h0000_0123);
      apply(1'b0, 1'b1, 2'd0, 12'h456);
      checks++;
      if (Extendido !== 32'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: data=%h valid=%b want data=00000000 valid=0",
                  Extendido, out_valid);
      end
      // Idle cycle after reset keeps the cleared value.
      apply(1'b1, 1'b0, 2'd0, 12'hABC);
      checks++;
      if (Extendido !== 32'h0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: data=%h valid=%b want data=00000000 valid=0",
                  Extendido, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         logic [11:0] e;
         logic [1:0]  m;
         e = 12'($urandom);
         m = 2'(i);
         apply(1'b1, 1'b1, m, e);
         checks++;
         if (Extendido !== model(e, m) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: in=%h mode=%0d data=%h valid=%b want %h valid=1",
                     e, m, Extendido, out_valid, model(e, m));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         logic        v;
         logic [11:0] e;
         logic [1:0]  m;
         v = ($urandom_range(3, 0) != 0);
         e = 12'($urandom);
         m = 2'($urandom_range(3, 0));
         apply(1'b1, v, m, e);
         checks++;
         if (Extendido !== exp_data || out_valid !== v) begin
            errors++;
            $display("FAIL random: in=%h mode=%0d v=%b data=%h valid=%b want %h valid=%b",
                     e, m, v, Extendido, out_valid, exp_data, v);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      mode     = 2'd0;
      Extender = 12'hFFF;
      exp_data = 32'h0;
      test_reset();
      test_sign_ext();
      test_zero_ext();
      test_branch();
      test_hold();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
